// File: rtl/rf_sched_pkg.sv
// Shared widths and types for the register-file writeback scheduler.
//   XLEN     : register data width
//   REG_AW   : register address width
//   NUM_REGS : number of architectural registers (x0..x31)
//   wb_req_t : one writeback request {valid, addr, data}
//   port_e   : writeback port index, used for the round-robin last_grant state
package rf_sched_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

    typedef enum logic {
        PORT_WB0 = 1'b0,
        PORT_WB1 = 1'b1
    } port_e;

endpackage

// File: rtl/rf_wb_scheduler_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk_i, rst_ni : clock, async active-low reset
//   req[1:0]      : request per port (bit 0 = wb0, bit 1 = wb1)
//   gnt[1:0]      : one-hot grant, or zero when nothing is requested
//   last_grant    : port granted in the most recent contended cycle
// A lone requester is always granted; on contention the port that lost the
// previous contention wins. last_grant moves only on contended cycles.
module rr_arb2
    import rf_sched_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output port_e      last_grant
);

    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last_grant == PORT_WB1) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Reset to wb1 so that wb0 wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state is always assigned with <= so all flops see pre-edge values.
        if (!rst_ni) begin
            last_grant <= PORT_WB1;
        end else if (req == 2'b11) begin
            last_grant <= gnt[1] ? PORT_WB1 : PORT_WB0;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback scheduler.
//   clk_i, rst_ni                   : clock, async active-low reset
//   wb0_valid_i/addr_i/data_i       : ALU writeback request; wb0_ready_o accept
//   wb1_valid_i/addr_i/data_i       : LSU/MDU writeback request; wb1_ready_o accept
//   lat_issue_i/lat_issue_addr_i    : long-latency issue, marks rd as pending
//   rs1_addr_i/rs2_addr_i           : hazard query addresses
//   rs1_busy_o/rs2_busy_o           : queried register has a pending long-latency write
//   rd_wren_o/rd_addr_o/rd_data_o   : registered register-file write port
// One writeback is accepted per cycle and written one cycle later. A busy
// vector tracks registers with an outstanding long-latency result; it is
// set on issue and cleared by the matching wb1 writeback.
module rf_wb_scheduler
    import rf_sched_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              wb0_valid_i,
    input  logic [REG_AW-1:0] wb0_addr_i,
    input  logic [XLEN-1:0]   wb0_data_i,
    output logic              wb0_ready_o,
    input  logic              wb1_valid_i,
    input  logic [REG_AW-1:0] wb1_addr_i,
    input  logic [XLEN-1:0]   wb1_data_i,
    output logic              wb1_ready_o,
    input  logic              lat_issue_i,
    input  logic [REG_AW-1:0] lat_issue_addr_i,
    input  logic [REG_AW-1:0] rs1_addr_i,
    input  logic [REG_AW-1:0] rs2_addr_i,
    output logic              rs1_busy_o,
    output logic              rs2_busy_o,
    output logic              rd_wren_o,
    output logic [REG_AW-1:0] rd_addr_o,
    output logic [XLEN-1:0]   rd_data_o
);

    wb_req_t             wb0_req;
    wb_req_t             wb1_req;
    wb_req_t             sel_req;
    logic [1:0]          gnt;
    port_e               unused_last_grant;
    logic                accept_any;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    assign wb0_req = '{valid: wb0_valid_i, addr: wb0_addr_i, data: wb0_data_i};
    assign wb1_req = '{valid: wb1_valid_i, addr: wb1_addr_i, data: wb1_data_i};

    rr_arb2 u_arb (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req        ({wb1_req.valid, wb0_req.valid}),
        .gnt        (gnt),
        .last_grant (unused_last_grant)
    );

    // A grant only exists for a valid request, so ready doubles as accept.
    assign wb0_ready_o = gnt[0];
    assign wb1_ready_o = gnt[1];
    assign accept_any  = |gnt;
    assign sel_req     = gnt[1] ? wb1_req : wb0_req;

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_wren_o <= 1'b0;
            rd_addr_o <= '0;
            rd_data_o <= '0;
        end else begin
            rd_wren_o <= accept_any && (sel_req.addr != '0);
            if (accept_any) begin
                rd_addr_o <= sel_req.addr;
                rd_data_o <= sel_req.data;
            end
        end
    end

    // Set and clear are one-hot decodes that skip x0, so busy[0] never rises.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (lat_issue_i && (lat_issue_addr_i != '0)) begin
            set_vec[lat_issue_addr_i] = 1'b1;
        end
        if (gnt[1] && (wb1_addr_i != '0)) begin
            clr_vec[wb1_addr_i] = 1'b1;
        end
    end

    // Set is OR-ed in after the clear so a same-address set wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: busy is a flop vector, not a RAM, so it is cleared by reset like any other state.
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= (busy_q & ~clr_vec) | set_vec;
        end
    end

    // Registered view only: a same-cycle set or clear shows up next cycle.
    assign rs1_busy_o = busy_q[rs1_addr_i];
    assign rs2_busy_o = busy_q[rs2_addr_i];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: a table of per-cycle vectors with
// expected ready/busy values, a queue of expected register-file writes, and
// a hand-written reset-during-operation sequence.
module tb_rf_wb_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wb0_valid_i, wb1_valid_i, lat_issue_i;
    logic [4:0]  wb0_addr_i, wb1_addr_i, lat_issue_addr_i, rs1_addr_i, rs2_addr_i;
    logic [31:0] wb0_data_i, wb1_data_i;
    logic        wb0_ready_o, wb1_ready_o, rs1_busy_o, rs2_busy_o, rd_wren_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    rf_wb_scheduler dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .wb0_valid_i      (wb0_valid_i),
        .wb0_addr_i       (wb0_addr_i),
        .wb0_data_i       (wb0_data_i),
        .wb0_ready_o      (wb0_ready_o),
        .wb1_valid_i      (wb1_valid_i),
        .wb1_addr_i       (wb1_addr_i),
        .wb1_data_i       (wb1_data_i),
        .wb1_ready_o      (wb1_ready_o),
        .lat_issue_i      (lat_issue_i),
        .lat_issue_addr_i (lat_issue_addr_i),
        .rs1_addr_i       (rs1_addr_i),
        .rs2_addr_i       (rs2_addr_i),
        .rs1_busy_o       (rs1_busy_o),
        .rs2_busy_o       (rs2_busy_o),
        .rd_wren_o        (rd_wren_o),
        .rd_addr_o        (rd_addr_o),
        .rd_data_o        (rd_data_o)
    );

    typedef struct {
        logic        v0;  logic [4:0] a0; logic [31:0] d0;
        logic        v1;  logic [4:0] a1; logic [31:0] d1;
        logic        li;  logic [4:0] la;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        e_rdy0, e_rdy1, e_b1, e_b2;
    } vec_t;

    typedef struct {
        logic        wren;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_payload;
    } exp_t;

    vec_t        vecs [21];
    exp_t        sb_q [$];
    logic [4:0]  hold_addr = '0;
    logic [31:0] hold_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(
        input logic v0, input logic [4:0] a0, input logic [31:0] d0,
        input logic v1, input logic [4:0] a1, input logic [31:0] d1,
        input logic li, input logic [4:0] la, input logic [4:0] r1, input logic [4:0] r2,
        input logic er0, input logic er1, input logic eb1, input logic eb2);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.li = li; v.la = la; v.r1 = r1; v.r2 = r2;
        v.e_rdy0 = er0; v.e_rdy1 = er1; v.e_b1 = eb1; v.e_b2 = eb2;
        return v;
    endfunction

    task automatic drive_idle();
        wb0_valid_i = 0; wb0_addr_i = 0; wb0_data_i = 0;
        wb1_valid_i = 0; wb1_addr_i = 0; wb1_data_i = 0;
        lat_issue_i = 0; lat_issue_addr_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0;
    endtask

    // Called at posedge+1: drive, check combinational outputs, queue the
    // expected write, then compare the registered write after the edge.
    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t got;
        wb0_valid_i = v.v0; wb0_addr_i = v.a0; wb0_data_i = v.d0;
        wb1_valid_i = v.v1; wb1_addr_i = v.a1; wb1_data_i = v.d1;
        lat_issue_i = v.li; lat_issue_addr_i = v.la;
        rs1_addr_i = v.r1; rs2_addr_i = v.r2;
        #1;
        check($sformatf("v%0d wb0_ready", idx), 32'(wb0_ready_o), 32'(v.e_rdy0));
        check($sformatf("v%0d wb1_ready", idx), 32'(wb1_ready_o), 32'(v.e_rdy1));
        check($sformatf("v%0d rs1_busy", idx), 32'(rs1_busy_o), 32'(v.e_b1));
        check($sformatf("v%0d rs2_busy", idx), 32'(rs2_busy_o), 32'(v.e_b2));
        if (v.e_rdy0) begin
            hold_addr = v.a0; hold_data = v.d0;
        end else if (v.e_rdy1) begin
            hold_addr = v.a1; hold_data = v.d1;
        end
        e.addr = hold_addr;
        e.data = hold_data;
        e.wren = (v.e_rdy0 || v.e_rdy1) && (hold_addr != 5'd0);
        e.chk_payload = e.wren || !(v.e_rdy0 || v.e_rdy1);
        sb_q.push_back(e);
        @(posedge clk_i);
        #1;
        got = sb_q.pop_front();
        check($sformatf("v%0d rd_wren", idx), 32'(rd_wren_o), 32'(got.wren));
        if (got.chk_payload) begin
            check($sformatf("v%0d rd_addr", idx), 32'(rd_addr_o), 32'(got.addr));
            check($sformatf("v%0d rd_data", idx), rd_data_o, got.data);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        //            v0 a0  d0            v1 a1  d1            li la  r1  r2  er0 er1 eb1 eb2
        vecs[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0,  0,  0,  1,  0,  0,  0);
        vecs[1]  = mk(1, 1,  32'hA0000001, 1, 2,  32'hB0000001, 0, 0,  0,  0,  1,  0,  0,  0);
        vecs[2]  = mk(1, 1,  32'hA0000002, 1, 2,  32'hB0000002, 0, 0,  0,  0,  0,  1,  0,  0);
        vecs[3]  = mk(1, 1,  32'hA0000003, 1, 2,  32'hB0000003, 0, 0,  0,  0,  1,  0,  0,  0);
        vecs[4]  = mk(1, 1,  32'hA0000004, 1, 2,  32'hB0000004, 0, 0,  0,  0,  0,  1,  0,  0);
        vecs[5]  = mk(1, 13, 32'h00000D0D, 0, 0,  32'h0,        0, 0,  0,  0,  1,  0,  0,  0);
        vecs[6]  = mk(1, 14, 32'h0E0E0E0E, 1, 15, 32'h0F0F0F0F, 0, 0,  0,  0,  1,  0,  0,  0);
        vecs[7]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  5,  7,  0,  0,  0,  0);
        vecs[8]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  7,  0,  0,  0,  0,  0);
        vecs[9]  = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  0,  0,  0,  1,  0);
        vecs[10] = mk(0, 0,  32'h0,        1, 7,  32'h00000077, 0, 0,  7,  0,  0,  1,  1,  0);
        vecs[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  7,  0,  0,  0,  0,  0);
        vecs[12] = mk(0, 0,  32'h0,        0, 0,  32'h0,        1, 9,  0,  9,  0,  0,  0,  0);
        vecs[13] = mk(0, 0,  32'h0,        1, 9,  32'h00000099, 1, 9,  0,  9,  0,  1,  0,  1);
        vecs[14] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  9,  0,  0,  0,  1);
        vecs[15] = mk(0, 0,  32'h0,        1, 9,  32'h00009999, 0, 0,  0,  9,  0,  1,  0,  1);
        vecs[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  9,  0,  0,  0,  0);
        vecs[17] = mk(1, 0,  32'h0000ABCD, 0, 0,  32'h0,        1, 0,  0,  0,  1,  0,  0,  0);
        vecs[18] = mk(1, 31, 32'hFFFF0000, 0, 0,  32'h0,        0, 0,  0,  31, 1,  0,  0,  0);
        vecs[19] = mk(1, 30, 32'h1E1E1E1E, 1, 31, 32'h1F1F1F1F, 0, 0,  0,  31, 0,  1,  0,  0);
        vecs[20] = mk(0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  0,  0,  0,  0,  0,  0);

        // Reset state.
        drive_idle();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset rd_wren", 32'(rd_wren_o), 32'd0);
        check("reset rd_addr", 32'(rd_addr_o), 32'd0);
        check("reset rd_data", rd_data_o, 32'd0);
        rst_ni = 1'b1;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Reset during operation: contention (wb0 wins, last_grant -> wb0),
        // issue x12, then reset while a write is visible and another is in flight.
        wb0_valid_i = 1; wb0_addr_i = 4; wb0_data_i = 32'hC0FFEE04;
        wb1_valid_i = 1; wb1_addr_i = 6; wb1_data_i = 32'hC0FFEE06;
        lat_issue_i = 1; lat_issue_addr_i = 12;
        #1;
        check("s6 wb0_ready", 32'(wb0_ready_o), 32'd1);
        check("s6 wb1_ready", 32'(wb1_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        drive_idle();
        wb1_valid_i = 1; wb1_addr_i = 8; wb1_data_i = 32'h88888888;
        rs1_addr_i = 12;
        #1;
        check("s6 pre rd_wren", 32'(rd_wren_o), 32'd1);
        check("s6 pre rd_addr", 32'(rd_addr_o), 32'd4);
        check("s6 pre busy12", 32'(rs1_busy_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("s6 rst rd_wren", 32'(rd_wren_o), 32'd0);
        check("s6 rst rd_addr", 32'(rd_addr_o), 32'd0);
        check("s6 rst rd_data", rd_data_o, 32'd0);
        check("s6 rst busy12", 32'(rs1_busy_o), 32'd0);
        drive_idle();
        rs1_addr_i = 12;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("s6 post rd_wren", 32'(rd_wren_o), 32'd0);
        check("s6 post busy12", 32'(rs1_busy_o), 32'd0);
        wb0_valid_i = 1; wb0_addr_i = 10; wb0_data_i = 32'h0A0A0A0A;
        wb1_valid_i = 1; wb1_addr_i = 11; wb1_data_i = 32'h0B0B0B0B;
        #1;
        check("s6 first wb0_ready", 32'(wb0_ready_o), 32'd1);
        check("s6 first wb1_ready", 32'(wb1_ready_o), 32'd0);
        @(posedge clk_i);
        #1;
        drive_idle();
        check("s6 first rd_wren", 32'(rd_wren_o), 32'd1);
        check("s6 first rd_addr", 32'(rd_addr_o), 32'd10);
        check("s6 first rd_data", rd_data_o, 32'h0A0A0A0A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rf_wb_scheduler.md
RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 Parameters: none. Widths come from rf_sched_pkg: XLEN=32 and REG_AW=5.
REQ-002 One clock and one reset: the reset is asynchronous and active-low, and the ports are named clk_i and rst_ni.
REQ-003 clk_i  in  1  clock; all state updates on the rising edge.
REQ-004 rst_ni  in  1  async active-low reset.
REQ-005 wb0_valid_i / wb0_addr_i / wb0_data_i  in  1/5/32  pipeline (ALU) writeback request.
REQ-006 wb0_ready_o  out  1  wb0 request accepted this cycle.
REQ-007 wb1_valid_i / wb1_addr_i / wb1_data_i  in  1/5/32  long-latency unit (LSU/MDU) writeback request.
REQ-008 wb1_ready_o  out  1  wb1 request accepted this cycle.
REQ-009 lat_issue_i / lat_issue_addr_i  in  1/5  long-latency op issued; marks its rd as pending.
REQ-010 rs1_addr_i / rs2_addr_i  in  5/5  hazard query addresses.
REQ-011 rs1_busy_o / rs2_busy_o  out  1/1  queried register has a pending long-latency write.
REQ-012 rd_wren_o / rd_addr_o / rd_data_o  out  1/5/32  register-file write port, registered.

Function
REQ-013 An accept on port N occurs when wbN_valid_i and wbN_ready_o are both 1 in the same cycle; wbN_ready_o is combinational from the grant.
REQ-014 When only one port is valid, that port is granted.
REQ-015 When both ports are valid, the port not granted in the most recent contended cycle is granted (round-robin via 1-bit last_grant); last_grant resets to 1, so wb0 wins the first contention.
REQ-016 last_grant updates only on contended cycles.
REQ-017 At most one port is accepted per cycle.
REQ-018 Write latency is 1: an accept in cycle t drives rd_wren_o=1, rd_addr_o and rd_data_o in cycle t+1; with no accept, rd_wren_o=0 in t+1 and rd_addr_o/rd_data_o hold their previous values.
REQ-019 An accept with addr=0 is consumed but produces rd_wren_o=0.
REQ-020 Scoreboard: a 32-bit busy vector; a lat_issue_i pulse with addr≠0 sets busy[addr] on the next edge.
REQ-021 A wb1 accept with addr≠0 clears busy[addr] on the next edge.
REQ-022 A wb0 accept never changes busy.
REQ-023 When a set and a clear hit the same address in the same cycle, the set wins.
REQ-024 A lat_issue_i to x0 is ignored, and busy[0] is constantly 0.
REQ-025 rsN_busy_o = busy[rsN_addr_i], read combinationally from the registered vector with no bypass of same-cycle set/clear.
REQ-026 Hazard timing: a clear and rd_wren_o both become visible in cycle t+1, so dependents rely on the register-file same-cycle write bypass.
REQ-027 A wb1 request to an address that is not busy is accepted normally, with no error.
REQ-028 Re-issuing to an already busy address keeps it busy; there is no counting.

Reset
REQ-029 When rst_ni=0, rd_wren_o=0, rd_addr_o=0, rd_data_o=0, busy=0, last_grant=1, all immediately and asynchronously.
REQ-030 A reset mid-operation drops any in-flight registered write: rd_wren_o is 0 in the first cycle after release.
REQ-031 wbN_ready_o and rsN_busy_o remain combinational during reset; they must not be used while reset is asserted.

Structure
REQ-032 rf_sched_pkg holds XLEN, REG_AW, NUM_REGS=32 and the typedef wb_req_t {valid, addr, data}.
REQ-033 A single sub-module, rr_arb2, provides the 2-way round-robin grant, taking req[1:0] and returning gnt[1:0] (one-hot or zero) plus last_grant state.
REQ-034 The scoreboard and the output register are inline.
REQ-035 Target size is 120-250 lines of RTL.

Verification
REQ-036 Scenario 1: wb0 only, addr=5, data=0xDEADBEEF → wb0_ready_o=1 in the same cycle; next cycle rd_wren_o=1, rd_addr_o=5, rd_data_o=0xDEADBEEF.
REQ-037 Scenario 2: both valid for 4 consecutive cycles (addrs 1 and 2) → grants wb0, wb1, wb0, wb1; exactly one ready per cycle.
REQ-038 Scenario 3: lat_issue to x7 → rs1_busy_o=1 for rs1_addr_i=7 from the next cycle; wb1 accept on x7 → busy=0 and rd_wren_o=1 (addr 7) in the same following cycle.
REQ-039 Scenario 4: lat_issue on x9 and a wb1 accept on x9 in the same cycle → x9 stays busy.
REQ-040 Scenario 5: wb0 accept to x0 → rd_wren_o=0 next cycle; lat_issue to x0 → rs1_busy_o=0 for rs1_addr_i=0.
REQ-041 Scenario 6: assert rst_ni=0 one cycle after an accept → rd_wren_o=0 immediately, busy cleared, and the first contention after release grants wb0.
